// File: rtl/tmr_pkg.sv
// Shared types for the TMR scrub-and-repair controller: FSM states,
// replica identifiers and vote masks.
package tmr_pkg;

  typedef enum logic [2:0] {
    ST_MONITOR,
    ST_REQUEST,
    ST_RECONFIG,
    ST_SETTLE,
    ST_FAILED
  } state_e;

  typedef logic [1:0] rid_t;
  typedef logic [2:0] mask_t;

  function automatic mask_t id2mask(input rid_t id);
    return mask_t'(3'b001 << id);
  endfunction

endpackage

// File: rtl/tmr_vote3.sv
// Combinational word-level 2-of-3 vote with optional exclusion of one replica.
// Reports whether the vote lacks a majority and which replicas disagree with it.
module tmr_vote3 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] r0_i,
  input  logic [WIDTH-1:0] r1_i,
  input  logic [WIDTH-1:0] r2_i,
  input  logic [2:0]       mask_i,
  output logic [WIDTH-1:0] vote_o,
  output logic             unc_o,
  output logic [2:0]       dis_o
);

  always_comb begin
    vote_o = r0_i;
    unc_o  = 1'b0;
    case (mask_i)
      // With one replica excluded, the lower-index survivor wins a tie.
      3'b001: begin
        vote_o = r1_i;
        unc_o  = (r1_i != r2_i);
      end
      3'b010: begin
        vote_o = r0_i;
        unc_o  = (r0_i != r2_i);
      end
      3'b100: begin
        vote_o = r0_i;
        unc_o  = (r0_i != r1_i);
      end
      default: begin
        if ((r0_i == r1_i) || (r0_i == r2_i)) begin
          vote_o = r0_i;
        end else if (r1_i == r2_i) begin
          vote_o = r1_i;
        end else begin
          vote_o = r0_i;
          unc_o  = 1'b1;
        end
      end
    endcase
    dis_o[0] = !mask_i[0] && (r0_i != vote_o);
    dis_o[1] = !mask_i[1] && (r1_i != vote_o);
    dis_o[2] = !mask_i[2] && (r2_i != vote_o);
  end

endmodule

// File: rtl/tmr_reconfig_ctrl.sv
// TMR voter front-end with persistent-fault detection, replica masking and a
// req/ack/done handshake to the partial-reconfiguration engine.
module tmr_reconfig_ctrl
  import tmr_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int THRESH         = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] out,
  output logic             uncorrectable,
  output logic [2:0]       mask,
  output logic             reconfig_req,
  output logic [1:0]       reconfig_id,
  input  logic             reconfig_ack,
  input  logic             reconfig_done,
  input  logic             reconfig_err,
  output logic             fault_perm
);

  localparam int CNT_W   = $clog2(THRESH + 1);
  localparam int CYC_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(THRESH);
  localparam logic [CYC_W-1:0]   TMO_LAST  = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0]   SET_LAST  = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  state_e                  state_q, state_d;
  mask_t                   mask_q, mask_d;
  rid_t                    id_q, id_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]        out_q;
  logic                    unc_q;

  logic [WIDTH-1:0]        vote;
  logic                    vote_unc;
  logic [2:0]              vote_dis;

  tmr_vote3 #(.WIDTH(WIDTH)) u_vote (
    .r0_i   (r0),
    .r1_i   (r1),
    .r2_i   (r2),
    .mask_i (mask_q),
    .vote_o (vote),
    .unc_o  (vote_unc),
    .dis_o  (vote_dis)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    id_d    = id_q;
    retry_d = retry_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_MONITOR: begin
        // A three-way split gives no trustworthy minority, so counters hold.
        if (!vote_unc) begin
          for (int i = 0; i < 3; i++) begin
            if (!vote_dis[i]) begin
              cnt_d[i] = '0;
            end else begin
              if (cnt_q[i] != CNT_SAT) cnt_d[i] = cnt_q[i] + CNT_W'(1);
              if (cnt_q[i] == CNT_LAST) begin
                state_d = ST_REQUEST;
                id_d    = rid_t'(i);
                mask_d  = id2mask(rid_t'(i));
                retry_d = '0;
              end
            end
          end
        end
      end
      ST_REQUEST: begin
        if (reconfig_ack) begin
          state_d = ST_RECONFIG;
          cyc_d   = '0;
        end
      end
      ST_RECONFIG: begin
        if (reconfig_done && !reconfig_err) begin
          state_d = ST_SETTLE;
          cyc_d   = '0;
        end else if ((reconfig_done && reconfig_err) || (cyc_q == TMO_LAST)) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_REQUEST;
          end else begin
            state_d = ST_FAILED;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cyc_q == SET_LAST) begin
          state_d     = ST_MONITOR;
          mask_d      = '0;
          cnt_d[id_q] = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_FAILED: ;
      default: state_d = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MONITOR;
      mask_q  <= '0;
      id_q    <= '0;
      retry_q <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      retry_q <= retry_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      out_q   <= vote;
      unc_q   <= vote_unc;
    end
  end

  assign out           = out_q;
  assign uncorrectable = unc_q;
  assign mask          = mask_q;
  assign reconfig_id   = id_q;
  assign reconfig_req  = (state_q == ST_REQUEST);
  assign fault_perm    = (state_q == ST_FAILED);

endmodule

// File: tb/tb_tmr_reconfig_ctrl.sv
// Directed bench for tmr_reconfig_ctrl: a cycle-level reference model checked
// on every falling edge, plus literal expectations at key points of each scenario.
module tb_tmr_reconfig_ctrl;

  localparam int W       = 8;
  localparam int THR     = 4;
  localparam int SETTLE  = 8;
  localparam int TMO     = 16;
  localparam int MAXR    = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] r0 = '0, r1 = '0, r2 = '0;
  logic [W-1:0] out;
  logic         uncorrectable;
  logic [2:0]   mask;
  logic         reconfig_req;
  logic [1:0]   reconfig_id;
  logic         reconfig_ack = 1'b0, reconfig_done = 1'b0, reconfig_err = 1'b0;
  logic         fault_perm;

  int checks   = 0;
  int failures = 0;

  tmr_reconfig_ctrl #(
    .WIDTH(W), .THRESH(THR), .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .r0(r0), .r1(r1), .r2(r2),
    .out(out), .uncorrectable(uncorrectable), .mask(mask),
    .reconfig_req(reconfig_req), .reconfig_id(reconfig_id),
    .reconfig_ack(reconfig_ack), .reconfig_done(reconfig_done),
    .reconfig_err(reconfig_err), .fault_perm(fault_perm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: tracks the excluded replica (-1 = none) and the phase of
  // the repair transaction with plain integers.
  logic [W-1:0] m_out = '0;
  bit           m_unc = 0;
  int           m_cnt[3] = '{0, 0, 0};
  int           m_bad = -1;
  int           m_id = 0;
  bit           m_req = 0, m_wait = 0, m_perm = 0;
  int           m_age = 0, m_settle = -1, m_retry = 0;
  bit           started = 0;

  function automatic void ref_vote(input logic [W-1:0] a, b, c, input int bad,
                                   output logic [W-1:0] v, output bit u);
    logic [W-1:0] rr[3];
    logic [W-1:0] keep[$];
    rr[0] = a; rr[1] = b; rr[2] = c;
    u = 0;
    if (bad < 0) begin
      if (a == b || a == c) v = a;
      else if (b == c) v = b;
      else begin v = a; u = 1; end
    end else begin
      for (int i = 0; i < 3; i++) if (i != bad) keep.push_back(rr[i]);
      v = keep[0];
      u = (keep[0] != keep[1]);
    end
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] v;
    logic [W-1:0] rr[3];
    bit u;
    started = 1;
    if (rst) begin
      m_out = '0; m_unc = 0; m_cnt = '{0, 0, 0}; m_bad = -1; m_id = 0;
      m_req = 0; m_wait = 0; m_perm = 0; m_age = 0; m_settle = -1; m_retry = 0;
    end else begin
      rr[0] = r0; rr[1] = r1; rr[2] = r2;
      ref_vote(r0, r1, r2, m_bad, v, u);
      if (m_perm) begin
      end else if (m_bad < 0) begin
        if (!u) begin
          for (int i = 0; i < 3; i++) begin
            if (rr[i] == v) m_cnt[i] = 0;
            else begin
              if (m_cnt[i] == THR - 1) begin
                m_bad = i; m_id = i; m_req = 1; m_retry = 0;
              end
              if (m_cnt[i] < THR) m_cnt[i]++;
            end
          end
        end
      end else if (m_req) begin
        if (reconfig_ack) begin m_req = 0; m_wait = 1; m_age = 0; end
      end else if (m_wait) begin
        m_age++;
        if (reconfig_done && !reconfig_err) begin
          m_wait = 0; m_settle = 0;
        end else if ((reconfig_done && reconfig_err) || m_age == TMO) begin
          m_wait = 0;
          if (m_retry < MAXR) begin m_retry++; m_req = 1; end
          else m_perm = 1;
        end
      end else if (m_settle >= 0) begin
        m_settle++;
        if (m_settle == SETTLE) begin
          m_settle = -1; m_cnt[m_bad] = 0; m_bad = -1;
        end
      end
      m_out = v; m_unc = u;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_out", out, m_out);
      chk("model_unc", uncorrectable, m_unc);
      chk("model_mask", mask, (m_bad >= 0) ? (32'd1 << m_bad) : 32'd0);
      chk("model_req", reconfig_req, m_req);
      chk("model_id", reconfig_id, m_id);
      chk("model_perm", fault_perm, m_perm);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [W-1:0] a, b, c);
    r0 = a; r1 = b; r2 = c;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_out", out, 0);
    chk("rst_unc", uncorrectable, 0);
    chk("rst_mask", mask, 0);
    chk("rst_req", reconfig_req, 0);
    chk("rst_id", reconfig_id, 0);
    chk("rst_perm", fault_perm, 0);
    rst = 1'b0;

    // Single glitch on r2, then three more: counter must have restarted
    set(5, 5, 5); tick(2);
    set(5, 5, 9); tick(1);
    chk("glitch_out", out, 5);
    chk("glitch_unc", uncorrectable, 0);
    set(5, 5, 5); tick(1);
    set(5, 5, 9); tick(3);
    set(5, 5, 5); tick(1);
    chk("glitch_noreq", reconfig_req, 0);

    // Persistent fault on r1
    set(7, 3, 7); tick(3);
    chk("pf_req_early", reconfig_req, 0);
    tick(1);
    chk("pf_req", reconfig_req, 1);
    chk("pf_id", reconfig_id, 1);
    chk("pf_mask", mask, 3'b010);
    chk("pf_out", out, 7);
    tick(2);
    reconfig_ack = 1'b1; tick(1); reconfig_ack = 1'b0;
    chk("pf_req_drop", reconfig_req, 0);
    set(7, 7, 7);
    tick(9);
    reconfig_done = 1'b1; tick(1); reconfig_done = 1'b0;
    chk("pf_mask_done", mask, 3'b010);
    tick(7);
    chk("pf_mask_settle7", mask, 3'b010);
    tick(1);
    chk("pf_mask_clear", mask, 3'b000);

    // r0 fault, same-cycle ack, double fault, timeout, then retry exhaustion
    set(1, 2, 2); tick(4);
    chk("r0_req", reconfig_req, 1);
    chk("r0_id", reconfig_id, 0);
    chk("r0_mask", mask, 3'b001);
    reconfig_ack = 1'b1; tick(1); reconfig_ack = 1'b0;
    chk("r0_req_drop", reconfig_req, 0);
    set(1, 2, 3); tick(1);
    chk("dbl_unc", uncorrectable, 1);
    chk("dbl_out", out, 2);
    set(2, 2, 2);
    tick(14);
    chk("tmo_early", reconfig_req, 0);
    tick(1);
    chk("tmo_rereq", reconfig_req, 1);
    reconfig_ack = 1'b1; tick(1); reconfig_ack = 1'b0;
    reconfig_done = 1'b1; reconfig_err = 1'b1; tick(1);
    reconfig_done = 1'b0; reconfig_err = 1'b0;
    chk("err1_rereq", reconfig_req, 1);
    chk("err1_perm", fault_perm, 0);
    reconfig_ack = 1'b1; tick(1); reconfig_ack = 1'b0;
    reconfig_done = 1'b1; reconfig_err = 1'b1; tick(1);
    reconfig_done = 1'b0; reconfig_err = 1'b0;
    chk("fail_perm", fault_perm, 1);
    chk("fail_mask", mask, 3'b001);
    chk("fail_req", reconfig_req, 0);
    set(9, 4, 4); tick(1);
    chk("fail_vote", out, 4);
    chk("fail_unc0", uncorrectable, 0);
    set(9, 4, 5); tick(1);
    chk("fail_vote_split", out, 4);
    chk("fail_unc1", uncorrectable, 1);
    tick(3);
    chk("fail_sticky", fault_perm, 1);

    // Reset clears FAILED; three-way split must hold counters
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst2_perm", fault_perm, 0);
    chk("rst2_mask", mask, 0);
    set(1, 2, 2); tick(3);
    set(1, 2, 3); tick(2);
    chk("tw_out", out, 1);
    chk("tw_unc", uncorrectable, 1);
    chk("tw_noreq", reconfig_req, 0);
    set(1, 2, 2); tick(1);
    chk("tw_hold_req", reconfig_req, 1);
    chk("tw_hold_id", reconfig_id, 0);

    // Reset in the middle of a reload
    reconfig_ack = 1'b1; tick(1); reconfig_ack = 1'b0;
    tick(3);
    chk("mid_mask", mask, 3'b001);
    rst = 1'b1; tick(1);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_unc", uncorrectable, 0);
    chk("mid_rst_mask", mask, 0);
    chk("mid_rst_req", reconfig_req, 0);
    chk("mid_rst_id", reconfig_id, 0);
    chk("mid_rst_perm", fault_perm, 0);
    rst = 1'b0;
    set(0, 0, 0); tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
